// File: rtl/img_fetch_sched_if.sv
// Bus bundle for img_fetch_sched: raster timing in, BRAM fetch strobes out,
// and the host filter-mode valid/ready handshake.
// Optional statistics signals exist only when FETCH_STATS_EN is defined.
interface img_fetch_sched_if #(
  parameter int ADDR_W = 15
);
  logic              pix_en;
  logic [9:0]        hc;
  logic [9:0]        vc;
  logic              blank;
  logic [ADDR_W-1:0] addra;
  logic              pix_valid;
  logic              line_start;
  logic              frame_start;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [1:0]        cfg_mode;
  logic [1:0]        mode;
`ifdef FETCH_STATS_EN
  logic [15:0]       frame_cnt;
  logic              fetch_err;
`endif

  modport master (
    input  pix_en, hc, vc, blank, cfg_valid, cfg_mode,
    output addra, pix_valid, line_start, frame_start, cfg_ready, mode
`ifdef FETCH_STATS_EN
    , output frame_cnt, fetch_err
`endif
  );

  modport slave (
    output pix_en, hc, vc, blank, cfg_valid, cfg_mode,
    input  addra, pix_valid, line_start, frame_start, cfg_ready, mode
`ifdef FETCH_STATS_EN
    , input frame_cnt, fetch_err
`endif
  );
endinterface

// File: rtl/img_fetch_sched.sv
// Image BRAM fetch sequencer behind the VGA timing generator.
// Issues BRAM addresses RD_LAT pixel ticks ahead of the on-screen window,
// flags window pixels / row / frame boundaries, and owns the filter-mode
// register, which is loaded by the host and applied only at frame start.
// Optional macro FETCH_STATS_EN adds frame_cnt and sticky fetch_err.
module img_fetch_sched #(
  parameter int IMG_W  = 160,
  parameter int IMG_H  = 115,
  parameter int X0     = 100,
  parameter int Y0     = 100,
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 15
) (
  input  logic               clock,
  input  logic               reset,
  img_fetch_sched_if.master  bus
);

  // Fetch columns lead the visible window columns by RD_LAT ticks.
  localparam logic [9:0] FX_LO  = 10'(X0 - RD_LAT);
  localparam logic [9:0] FX_HI  = 10'(X0 + IMG_W - RD_LAT);
  localparam logic [9:0] WX_LO  = 10'(X0);
  localparam logic [9:0] WX_HI  = 10'(X0 + IMG_W);
  localparam logic [9:0] WY_LO  = 10'(Y0);
  localparam logic [9:0] WY_HI  = 10'(Y0 + IMG_H);
  localparam logic [9:0] LAST_X = 10'(X0 + IMG_W - 1);
  localparam logic [9:0] LAST_Y = 10'(Y0 + IMG_H - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACTIVE,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nx;

  logic [ADDR_W-1:0] addra_q;
  logic [ADDR_W-1:0] fetch_addr;
  logic              wrap_q;
  logic              pv_q;
  logic              ls_q;
  logic              fs_q;
  logic              ready_q;
  logic [1:0]        pend_q;
  logic [1:0]        mode_q;

  logic              frame_tick;
  logic              in_fx;
  logic              in_wx;
  logic              in_wy;
  logic              fetch;
  logic              pv_nx;
  logic              xfer;

  // Raster decode: window membership, fetch strobe and next fetch address.
  always_comb begin
    frame_tick = bus.pix_en && (bus.hc == '0) && (bus.vc == '0);
    in_fx      = (bus.hc >= FX_LO) && (bus.hc < FX_HI);
    in_wx      = (bus.hc >= WX_LO) && (bus.hc < WX_HI);
    in_wy      = (bus.vc >= WY_LO) && (bus.vc < WY_HI);
    fetch      = bus.pix_en && in_fx && in_wy &&
                 ((state == ACTIVE) || ((state == WAIT) && (bus.vc == WY_LO)));
    // The first fetch of a frame restarts at 0; every later one increments.
    fetch_addr = ((bus.hc == FX_LO) && (bus.vc == WY_LO)) ? '0
                                                          : addra_q + ADDR_W'(1);
    pv_nx      = bus.pix_en && in_wx && in_wy && !bus.blank && (state != IDLE);
    xfer       = bus.cfg_valid && ready_q;
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // FSM next-state: all transitions happen on pixel ticks only.
  always_comb begin
    state_nx = state;
    if (bus.pix_en) begin
      case (state)
        IDLE:    if (frame_tick) state_nx = WAIT;
        WAIT:    if (bus.vc == WY_LO) state_nx = ACTIVE;
        ACTIVE:  if ((bus.vc == LAST_Y) && (bus.hc == LAST_X)) state_nx = DONE;
        DONE:    if (frame_tick) state_nx = WAIT;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Address generator and one-clock-wide pixel/row/frame strobes.
  always_ff @(posedge clock) begin
    if (reset) begin
      addra_q <= '0;
      wrap_q  <= 1'b0;
      pv_q    <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      pv_q <= pv_nx;
      ls_q <= pv_nx && (bus.hc == WX_LO);
      fs_q <= frame_tick;
      if (frame_tick) begin
        addra_q <= '0;
        wrap_q  <= 1'b0;
      end else if (fetch) begin
        addra_q <= fetch_addr;
        wrap_q  <= (fetch_addr == LAST_ADDR);
      end else if (bus.pix_en && wrap_q) begin
        addra_q <= '0;
        wrap_q  <= 1'b0;
      end
    end
  end

  // Single-entry pending slot for the filter mode; applied at frame start.
  // A transfer needs an empty slot, so it never coincides with draining it;
  // a value accepted on the frame-start clock therefore waits a full frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      ready_q <= 1'b1;
      pend_q  <= '0;
      mode_q  <= '0;
    end else begin
      if (frame_tick && !ready_q) mode_q <= pend_q;
      if (xfer) begin
        ready_q <= 1'b0;
        pend_q  <= bus.cfg_mode;
      end else if (frame_tick) begin
        ready_q <= 1'b1;
      end
    end
  end

  assign bus.addra       = addra_q;
  assign bus.pix_valid   = pv_q;
  assign bus.line_start  = ls_q;
  assign bus.frame_start = fs_q;
  assign bus.cfg_ready   = ready_q;
  assign bus.mode        = mode_q;

`ifdef FETCH_STATS_EN
  localparam logic [ADDR_W:0] FETCH_TOTAL = (ADDR_W + 1)'(IMG_W * IMG_H);

  logic [15:0]     frame_cnt_q;
  logic            fetch_err_q;
  logic [ADDR_W:0] fetch_cnt_q;

  // Frame counter and per-frame fetch audit checked on DONE -> WAIT.
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_cnt_q <= '0;
      fetch_err_q <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      if (frame_tick && (state != IDLE)) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (frame_tick && (state == DONE) && (fetch_cnt_q != FETCH_TOTAL))
        fetch_err_q <= 1'b1;
      if (frame_tick)  fetch_cnt_q <= '0;
      else if (fetch)  fetch_cnt_q <= fetch_cnt_q + (ADDR_W + 1)'(1);
    end
  end

  assign bus.frame_cnt = frame_cnt_q;
  assign bus.fetch_err = fetch_err_q;
`endif

endmodule

// File: tb/tb_img_fetch_sched.sv
// Scoreboard bench for img_fetch_sched on a shrunken raster (20x10 ticks,
// 8x4 window at column 6 / line 3, RD_LAT=2). Stimulus computes expected
// outputs from raster coordinates and pushes them; a monitor pops/compares.
module tb_img_fetch_sched;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int X0 = 6;
  localparam int Y0 = 3;
  localparam int RL = 2;
  localparam int AW = 6;
  localparam int HT = 20;
  localparam int VT = 10;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  img_fetch_sched_if #(.ADDR_W(AW)) bus ();

  img_fetch_sched #(
    .IMG_W(W), .IMG_H(H), .X0(X0), .Y0(Y0), .RD_LAT(RL), .ADDR_W(AW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [AW-1:0] addra;
    logic          pv;
    logic          ls;
    logic          fs;
    logic          rdy;
    logic [1:0]    mode;
    logic [15:0]   fcnt;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_errs   = 0;

  // Reference model state (spec-level: addresses from coordinates).
  int   rh = 7, rv = 5;
  int   m_addra = 0, m_pval = 0, m_mode = 0, m_fcnt = 0;
  bit   m_wrap = 0, m_sync = 0, m_full = 0;
  bit   hv = 0;
  logic [1:0] hm = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", nm, $time, act, exp);
    end
  endtask

  task automatic step(input bit rst, input bit pen, input bit glitch, output bit acc);
    exp_t e;
    bit blk, ft, fetch, pv, ls;
    int x, y, a;
    @(negedge clock);
    blk = glitch || (rh >= 16) || (rv >= 8);
    reset         = rst;
    bus.pix_en    = pen;
    bus.hc        = 10'(rh);
    bus.vc        = 10'(rv);
    bus.blank     = blk;
    bus.cfg_valid = hv;
    bus.cfg_mode  = hm;
    acc = 0; pv = 0; ls = 0; ft = 0;
    if (rst) begin
      m_addra = 0; m_wrap = 0; m_sync = 0; m_full = 0;
      m_pval = 0; m_mode = 0; m_fcnt = 0;
    end else begin
      ft = pen && rh == 0 && rv == 0;
      x = rh + RL - X0;
      y = rv - Y0;
      fetch = pen && m_sync && x >= 0 && x < W && y >= 0 && y < H;
      pv = pen && m_sync && rh >= X0 && rh < X0 + W && rv >= Y0 && rv < Y0 + H && !blk;
      ls = pv && rh == X0;
      if (ft) begin
        m_addra = 0; m_wrap = 0;
      end else if (fetch) begin
        a = y * W + x;
        m_addra = a;
        m_wrap = (a == W * H - 1);
      end else if (pen && m_wrap) begin
        m_addra = 0; m_wrap = 0;
      end
      acc = hv && !m_full;
      if (ft && m_full) begin
        m_mode = m_pval; m_full = 0;
      end
      if (acc) begin
        m_full = 1; m_pval = hm;
      end
      if (ft && m_sync) m_fcnt = (m_fcnt + 1) % 65536;
      if (ft) m_sync = 1;
    end
    e.addra = AW'(m_addra);
    e.pv    = pv;
    e.ls    = ls;
    e.fs    = ft;
    e.rdy   = !m_full;
    e.mode  = 2'(m_mode);
    e.fcnt  = 16'(m_fcnt);
    sbq.push_back(e);
    if (pen) begin
      rh++;
      if (rh == HT) begin
        rh = 0; rv++;
        if (rv == VT) rv = 0;
      end
    end
  endtask

  // One clock with a host that holds cfg_valid until accepted.
  task automatic clk(input bit rst, input bit pen, input bit glitch, input bit cfg_on);
    bit acc;
    if (cfg_on && !hv && $urandom_range(0, 15) == 0) begin
      hv = 1; hm = 2'($urandom_range(0, 3));
    end
    step(rst, pen, glitch, acc);
    if (acc) hv = 0;
  endtask

  task automatic run(input int ticks, input bit jitter, input bit cfg_on);
    for (int i = 0; i < ticks; i++) begin
      int gap;
      gap = jitter ? $urandom_range(1, 3) : 1;
      for (int g = 0; g < gap; g++) clk(0, 0, 0, cfg_on);
      clk(0, 1, jitter && $urandom_range(0, 7) == 0, cfg_on);
    end
  endtask

  // Monitor: compare every DUT output against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("addra",       32'(bus.addra),       32'(e.addra));
        chk("pix_valid",   32'(bus.pix_valid),   32'(e.pv));
        chk("line_start",  32'(bus.line_start),  32'(e.ls));
        chk("frame_start", 32'(bus.frame_start), 32'(e.fs));
        chk("cfg_ready",   32'(bus.cfg_ready),   32'(e.rdy));
        chk("mode",        32'(bus.mode),        32'(e.mode));
`ifdef FETCH_STATS_EN
        chk("frame_cnt",   32'(bus.frame_cnt),   32'(e.fcnt));
        chk("fetch_err",   32'(bus.fetch_err),   32'd0);
`endif
      end
    end
  end

  initial begin
    int guard;
    bus.pix_en = 1'b0; bus.hc = '0; bus.vc = '0; bus.blank = 1'b1;
    bus.cfg_valid = 1'b0; bus.cfg_mode = '0;
    repeat (3) clk(1, 0, 0, 0);
    // Unsynchronised start mid-frame, then regular ticks every 2nd clock.
    run(HT * VT * 3 + 50, 0, 1);
    // Irregular tick spacing with random blanking glitches.
    run(HT * VT * 3, 1, 1);
    // Drain host traffic so the pending slot is empty at a frame start.
    run(HT * VT * 2, 0, 0);
    guard = 0;
    while (!(rh == 0 && rv == 0) && guard < HT * VT) begin
      run(1, 0, 0);
      guard++;
    end
    chk("align_frame_start", 32'(guard < HT * VT), 32'd1);
    // Transfer on the frame-start clock itself with the slot empty.
    clk(0, 0, 0, 0);
    hv = 1; hm = 2'd3;
    clk(0, 1, 0, 0);
    run(HT * VT * 2, 0, 0);
    // Mid-window reset, then resynchronise on later frames.
    guard = 0;
    while (!(rh == 8 && rv == 5) && guard < HT * VT) begin
      run(1, 0, 1);
      guard++;
    end
    chk("align_mid_reset", 32'(guard < HT * VT), 32'd1);
    hv = 0;
    repeat (2) clk(1, 0, 0, 0);
    run(HT * VT * 2 + 30, 0, 1);
    repeat (3) @(posedge clock);
    #2;
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
